// File: rtl/dcache_vector_banked_if.sv
// Request/response bundle for the banked vector data memory.
interface dcache_vector_banked_if #(
    parameter int WIDTH      = 32,
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 16
);
    logic                          req_valid;
    logic                          req_ready;
    logic [WIDTH-1:0]              address;
    logic                          write;
    logic [LANES-1:0]              lane_mask;
    logic                          splat;
    logic [LANES*LANE_WIDTH-1:0]   data_in;
    logic                          rsp_valid;
    logic                          rsp_err;
    logic [LANES*LANE_WIDTH-1:0]   data_out;
    logic                          init_done;

    modport master (
        output req_valid, address, write, lane_mask, splat, data_in,
        input  req_ready, rsp_valid, rsp_err, data_out, init_done
    );

    modport slave (
        input  req_valid, address, write, lane_mask, splat, data_in,
        output req_ready, rsp_valid, rsp_err, data_out, init_done
    );
endinterface

// File: rtl/dcache_vector_banked.sv
// Vector data memory with per-lane masked/splat writes and misalignment flagging.
// Preloads entry[i] lane 0 = i after reset; reads respond one cycle after acceptance.
module dcache_vector_banked #(
    parameter int WIDTH      = 32,
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 16,
    parameter int DEPTH      = 128
) (
    input logic                  CLK,
    input logic                  RST,
    dcache_vector_banked_if.slave bus
);
    localparam int VEC_WIDTH = LANES * LANE_WIDTH;
    localparam int OFS       = $clog2(VEC_WIDTH / 8);
    localparam int IDXW      = $clog2(DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           r_state;
    logic [IDXW-1:0]      r_ptr;
    logic                 r_ready;
    logic                 r_init_done;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [VEC_WIDTH-1:0] r_data_out;
    logic [VEC_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_xfer;
    logic                  w_misaligned;
    logic [IDXW-1:0]       w_index;
    logic [LANE_WIDTH-1:0] w_init_lane;
    logic                  w_unused_addr;

    assign w_xfer        = bus.req_valid && r_ready;
    assign w_misaligned  = |bus.address[OFS-1:0];
    assign w_index       = bus.address[OFS+IDXW-1:OFS];
    assign w_init_lane   = LANE_WIDTH'(r_ptr);
    // High address bits only alias; they never select anything.
    assign w_unused_addr = ^bus.address[WIDTH-1:OFS+IDXW];

    assign bus.req_ready = r_ready;
    assign bus.init_done = r_init_done;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.data_out  = r_data_out;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_INIT;
            r_ptr       <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == IDXW'(DEPTH - 1)) begin
                        r_state     <= ST_RUN;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (!bus.write) begin
                            r_rsp_valid <= 1'b1;
                            r_data_out  <= r_mem[w_index];
                        end
                    end
                end
            endcase
        end
    end

    // Storage carries no reset; contents are only meaningful after the preload.
    always_ff @(posedge CLK) begin
        if (r_state == ST_INIT) begin
            r_mem[r_ptr] <= {{(VEC_WIDTH-LANE_WIDTH){1'b0}}, w_init_lane};
        end else if (w_xfer && bus.write && !w_misaligned) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.lane_mask[k]) begin
                    r_mem[w_index][k*LANE_WIDTH +: LANE_WIDTH] <= bus.splat ?
                        bus.data_in[LANE_WIDTH-1:0] :
                        bus.data_in[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_dcache_vector_banked.sv
// Directed table-driven bench for dcache_vector_banked with hand-written reset/back-to-back sequences.
module tb_dcache_vector_banked;
    logic CLK;
    logic RST;

    int n_cmp  = 0;
    int n_fail = 0;

    dcache_vector_banked_if bus ();

    dcache_vector_banked dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        splat;
        logic [63:0] data;
        logic        evld;
        logic        eerr;
        logic [63:0] edout;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 64'(bus.req_ready), 64'h0);
        chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'h0);
        chk({tag, " rsp_err"},   64'(bus.rsp_err),   64'h0);
        chk({tag, " data_out"},  bus.data_out,       64'h0);
        chk({tag, " init_done"}, 64'(bus.init_done), 64'h0);
    endtask

    // Called just after RST release on a falling edge; counts rising edges to init_done.
    task automatic wait_init(output int cycles, output logic early_ready);
        cycles      = 0;
        early_ready = 1'b0;
        while (bus.init_done !== 1'b1 && cycles < 400) begin
            @(posedge CLK);
            cycles++;
            @(negedge CLK);
            if (bus.req_ready === 1'b1 && bus.init_done !== 1'b1) early_ready = 1'b1;
        end
    endtask

    // Single transfer driven from a falling edge; returns on the next falling edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                        input logic sp, input logic [63:0] data);
        bus.req_valid = 1'b1;
        bus.write     = wr;
        bus.address   = addr;
        bus.lane_mask = mask;
        bus.splat     = sp;
        bus.data_in   = data;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int   cycles;
        logic early;

        tbl[0]  = '{1'b0, 32'h28,  4'h0, 1'b0, 64'h0,                  1'b1, 1'b0, 64'h5};
        tbl[1]  = '{1'b0, 32'h3F8, 4'h0, 1'b0, 64'h0,                  1'b1, 1'b0, 64'h7F};
        tbl[2]  = '{1'b1, 32'h40,  4'b0101, 1'b0, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 64'h7F};
        tbl[3]  = '{1'b0, 32'h40,  4'h0, 1'b0, 64'h0,                  1'b1, 1'b0, 64'h0000_2222_0000_4444};
        tbl[4]  = '{1'b1, 32'h48,  4'b1110, 1'b1, 64'h0000_0000_0000_BEEF, 1'b0, 1'b0, 64'h0000_2222_0000_4444};
        tbl[5]  = '{1'b0, 32'h48,  4'h0, 1'b0, 64'h0,                  1'b1, 1'b0, 64'hBEEF_BEEF_BEEF_0009};
        tbl[6]  = '{1'b0, 32'h43,  4'h0, 1'b0, 64'h0,                  1'b1, 1'b1, 64'hBEEF_BEEF_BEEF_0009};
        tbl[7]  = '{1'b1, 32'h41,  4'hF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'hBEEF_BEEF_BEEF_0009};
        tbl[8]  = '{1'b0, 32'h40,  4'h0, 1'b0, 64'h0,                  1'b1, 1'b0, 64'h0000_2222_0000_4444};
        tbl[9]  = '{1'b1, 32'h400, 4'hF, 1'b0, 64'hA,                  1'b0, 1'b0, 64'h0000_2222_0000_4444};
        tbl[10] = '{1'b0, 32'h0,   4'h0, 1'b0, 64'h0,                  1'b1, 1'b0, 64'hA};
        tbl[11] = '{1'b1, 32'h10,  4'hF, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 64'hA};
        tbl[12] = '{1'b0, 32'h10,  4'h0, 1'b0, 64'h0,                  1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0};
        tbl[13] = '{1'b1, 32'h18,  4'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0};
        tbl[14] = '{1'b0, 32'h18,  4'h0, 1'b0, 64'h0,                  1'b1, 1'b0, 64'h3};

        RST           = 1'b0;
        bus.req_valid = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.lane_mask = '0;
        bus.splat     = 1'b0;
        bus.data_in   = '0;

        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b1;
        wait_init(cycles, early);
        chk("preload cycles", 64'(cycles), 64'd128);
        chk("ready during init", 64'(early), 64'h0);
        chk("ready after init", 64'(bus.req_ready), 64'h1);

        // Back-to-back reads of index 1,2,3 with req_valid held high.
        for (int i = 1; i <= 3; i++) begin
            bus.req_valid = 1'b1;
            bus.write     = 1'b0;
            bus.address   = 32'(i * 8);
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("b2b%0d rsp_valid", i), 64'(bus.rsp_valid), 64'h1);
            chk($sformatf("b2b%0d lane0", i), 64'(bus.data_out[15:0]), 64'(i));
        end
        bus.req_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("idle rsp_valid", 64'(bus.rsp_valid), 64'h0);

        for (int i = 0; i < 15; i++) begin
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].mask, tbl[i].splat, tbl[i].data);
            chk($sformatf("vec%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(tbl[i].evld));
            chk($sformatf("vec%0d rsp_err", i),   64'(bus.rsp_err),   64'(tbl[i].eerr));
            chk($sformatf("vec%0d data_out", i),  bus.data_out,       tbl[i].edout);
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("pulse width", 64'(bus.rsp_valid), 64'h0);

        // Reset while a response is being presented.
        bus.req_valid = 1'b1;
        bus.write     = 1'b0;
        bus.address   = 32'h40;
        @(posedge CLK);
        #2;
        bus.req_valid = 1'b0;
        chk("pre-reset rsp_valid", 64'(bus.rsp_valid), 64'h1);
        RST = 1'b0;
        #1;
        check_reset_outputs("run reset");
        @(negedge CLK);
        RST = 1'b1;

        // Reset again 50 cycles into the preload.
        repeat (50) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_reset_outputs("init reset");
        @(negedge CLK);
        RST = 1'b1;
        wait_init(cycles, early);
        chk("re-preload cycles", 64'(cycles), 64'd128);
        chk("re-preload early ready", 64'(early), 64'h0);

        xfer(1'b0, 32'h28, 4'h0, 1'b0, 64'h0);
        chk("re-preload rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("re-preload idx5", bus.data_out, 64'h5);
        xfer(1'b0, 32'h400, 4'h0, 1'b0, 64'h0);
        chk("re-preload idx0 alias", bus.data_out, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
